// File: rtl/gates_bist_pkg.sv
// Shared types and the golden gate model for the 2-input gate-unit self-test.
package gates_bist_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StCheck,
        StFinish
    } bist_state_e;

    localparam int unsigned ResW    = 7;
    localparam int unsigned IdxAnd  = 6;
    localparam int unsigned IdxNot  = 5;
    localparam int unsigned IdxOr   = 4;
    localparam int unsigned IdxXor  = 3;
    localparam int unsigned IdxXnor = 2;
    localparam int unsigned IdxNand = 1;
    localparam int unsigned IdxNor  = 0;

    function automatic logic [ResW-1:0] golden(input logic a, input logic b);
        logic [ResW-1:0] r;
        r          = '0;
        r[IdxAnd]  = a & b;
        r[IdxNot]  = ~a;
        r[IdxOr]   = a | b;
        r[IdxXor]  = a ^ b;
        r[IdxXnor] = ~(a ^ b);
        r[IdxNand] = ~(a & b);
        r[IdxNor]  = ~(a | b);
        return r;
    endfunction

endpackage

// File: rtl/gates_golden.sv
// Combinational reference model of the gate unit: {a,b} -> expected 7-bit result.
module gates_golden
    import gates_bist_pkg::*;
(
    input  logic            a_i,
    input  logic            b_i,
    output logic [ResW-1:0] exp_o
);

    assign exp_o = golden(a_i, b_i);

endmodule

// File: rtl/gates_bist_checker.sv
// Self-test engine: sweeps {a,b} through 00..11, compares the gate unit against the golden
// model, counts mismatching vectors and captures the first failure.
module gates_bist_checker
    import gates_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned NUM_PASSES    = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_out,
    output logic             b_out,
    input  logic [6:0]       dut_res,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       fail_vec,
    output logic [6:0]       fail_mask
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SW-1:0] SettleLast = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PassLast   = PW'(NUM_PASSES - 1);

    bist_state_e      state_q;
    logic [SW-1:0]    settle_q;
    logic [1:0]       vec_q;
    logic [PW-1:0]    pass_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] err_q;
    logic [1:0]       fail_vec_q;
    logic [6:0]       fail_mask_q;

    logic [ResW-1:0]  expected;
    logic [ResW-1:0]  diff;
    logic             mismatch;
    logic [ERR_W-1:0] err_inc;

    gates_golden u_golden (
        .a_i   (vec_q[1]),
        .b_i   (vec_q[0]),
        .exp_o (expected)
    );

    assign diff     = expected ^ dut_res;
    assign mismatch = |diff;
    assign err_inc  = (mismatch && (err_q != {ERR_W{1'b1}})) ? err_q + ERR_W'(1) : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            settle_q    <= '0;
            vec_q       <= '0;
            pass_cnt_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            fail_vec_q  <= '0;
            fail_mask_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q      <= 1'b1;
                        vec_q       <= '0;
                        pass_cnt_q  <= '0;
                        settle_q    <= '0;
                        err_q       <= '0;
                        fail_vec_q  <= '0;
                        fail_mask_q <= '0;
                        pass_q      <= 1'b0;
                        state_q     <= StSettle;
                    end
                end
                StSettle: begin
                    if (settle_q == SettleLast) begin
                        settle_q <= '0;
                        state_q  <= StCheck;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                StCheck: begin
                    err_q <= err_inc;
                    // err_q only grows within a run, so zero means no earlier failure
                    if (mismatch && (err_q == '0)) begin
                        fail_vec_q  <= vec_q;
                        fail_mask_q <= diff;
                    end
                    if ((vec_q == 2'b11) && (pass_cnt_q == PassLast)) begin
                        state_q <= StFinish;
                    end else begin
                        if (vec_q == 2'b11) begin
                            pass_cnt_q <= pass_cnt_q + PW'(1);
                        end
                        vec_q   <= vec_q + 2'd1;
                        state_q <= StSettle;
                    end
                end
                StFinish: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_q == '0);
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign a_out     = vec_q[1];
    assign b_out     = vec_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_vec_q;
    assign fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gates_bist_checker.sv
// Bench for gates_bist_checker: a fault-injectable gate unit feeds three checker instances.
module tb_gates_bist_checker;

    localparam int VecLen = 3;  // SETTLE_CYCLES + 1 with the default settle time

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [6:0] inv_m, sa0_m, sa1_m;

    logic       a1, b1, busy1, done1, pass1;
    logic [7:0] err1;
    logic [1:0] fv1;
    logic [6:0] fm1, r1;
    logic       a2, b2, busy2, done2, pass2;
    logic [7:0] err2;
    logic [1:0] fv2;
    logic [6:0] fm2, r2;
    logic       a3, b3, busy3, done3, pass3;
    logic [1:0] err3;
    logic [1:0] fv3;
    logic [6:0] fm3, r3;

    int errors = 0;
    int checks = 0;

    function automatic logic [6:0] ref_gates(input logic a, input logic b);
        return {a & b, ~a, a | b, a ^ b, ~(a ^ b), ~(a & b), ~(a | b)};
    endfunction

    function automatic logic [6:0] unit_out(input logic a, input logic b, input logic [6:0] inv,
                                            input logic [6:0] sa0, input logic [6:0] sa1);
        return ((ref_gates(a, b) ^ inv) | sa1) & ~sa0;
    endfunction

    assign r1 = unit_out(a1, b1, inv_m, sa0_m, sa1_m);
    assign r2 = unit_out(a2, b2, inv_m, sa0_m, sa1_m);
    assign r3 = unit_out(a3, b3, inv_m, sa0_m, sa1_m);

    gates_bist_checker dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a1), .b_out(b1), .dut_res(r1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1),
        .fail_mask(fm1)
    );

    gates_bist_checker #(.NUM_PASSES(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a2), .b_out(b2), .dut_res(r2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2),
        .fail_mask(fm2)
    );

    gates_bist_checker #(.NUM_PASSES(3), .ERR_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_out(a3), .b_out(b3), .dut_res(r3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vec(fv3),
        .fail_mask(fm3)
    );

    typedef struct {
        logic [6:0] inv;
        logic [6:0] sa0;
        logic [6:0] sa1;
        int         err;
        logic [1:0] fv;
        logic [6:0] fm;
        logic       ps;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic get(input int sel, output logic bz, output logic dn, output logic ps,
                       output logic [31:0] er, output logic [1:0] fv, output logic [6:0] fm,
                       output logic [1:0] ab);
        case (sel)
            1: begin
                bz = busy1; dn = done1; ps = pass1; er = 32'(err1); fv = fv1; fm = fm1;
                ab = {a1, b1};
            end
            2: begin
                bz = busy2; dn = done2; ps = pass2; er = 32'(err2); fv = fv2; fm = fm2;
                ab = {a2, b2};
            end
            default: begin
                bz = busy3; dn = done3; ps = pass3; er = 32'(err3); fv = fv3; fm = fm3;
                ab = {a3, b3};
            end
        endcase
    endtask

    // Reference: walk the sweep the way the unit is exercised, tallying failures.
    task automatic model_run(input int n, input int w, output int e, output logic [1:0] fv,
                             output logic [6:0] fm, output logic ps);
        int         cnt;
        int         sat;
        logic [1:0] v2;
        logic [6:0] x;
        cnt = 0;
        sat = (1 << w) - 1;
        fv  = '0;
        fm  = '0;
        for (int p = 0; p < n; p++) begin
            for (int v = 0; v < 4; v++) begin
                v2 = 2'(v);
                x  = ref_gates(v2[1], v2[0]) ^ unit_out(v2[1], v2[0], inv_m, sa0_m, sa1_m);
                if (x != 0) begin
                    if (cnt == 0) begin
                        fv = v2;
                        fm = x;
                    end
                    if (cnt < sat) cnt++;
                end
            end
        end
        e  = cnt;
        ps = (cnt == 0);
    endtask

    task automatic run(input int sel, input int n, input int pulse_at);
        logic        bz, dn, ps;
        logic [31:0] er;
        logic [1:0]  fv, ab;
        logic [6:0]  fm;
        int          k;
        int          limit;
        bit          seq_ok;
        limit  = 4 * n * VecLen + 40;
        seq_ok = 1'b1;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        get(sel, bz, dn, ps, er, fv, fm, ab);
        check($sformatf("busy_after_start[%0d]", sel), 32'(bz), 1);
        check($sformatf("err_cleared_at_start[%0d]", sel), er, 0);
        if (ab != 2'b00) seq_ok = 1'b0;
        while (!dn && k < limit) begin
            @(posedge clk); #1;
            k++;
            if (k == pulse_at) start = 1'b1;
            else if (k == pulse_at + 1) start = 1'b0;
            get(sel, bz, dn, ps, er, fv, fm, ab);
            if (!dn && k < 4 * n * VecLen && ab != 2'((k / VecLen) % 4)) seq_ok = 1'b0;
        end
        check($sformatf("done_latency[%0d]", sel), 32'(k), 32'(4 * n * VecLen + 1));
        check($sformatf("busy_at_done[%0d]", sel), 32'(bz), 0);
        check($sformatf("ab_sequence[%0d]", sel), 32'(seq_ok), 1);
    endtask

    task automatic check_results(input int sel, input int e, input logic [1:0] efv,
                                 input logic [6:0] efm, input logic eps);
        logic        bz, dn, ps;
        logic [31:0] er;
        logic [1:0]  fv, ab;
        logic [6:0]  fm;
        get(sel, bz, dn, ps, er, fv, fm, ab);
        check($sformatf("err_count[%0d]", sel), er, 32'(e));
        check($sformatf("fail_vec[%0d]", sel), 32'(fv), 32'(efv));
        check($sformatf("fail_mask[%0d]", sel), 32'(fm), 32'(efm));
        check($sformatf("pass[%0d]", sel), 32'(ps), 32'(eps));
    endtask

    task automatic settle_all(input int sel);
        logic        bz, dn, ps;
        logic [31:0] er;
        logic [1:0]  fv, ab;
        logic [6:0]  fm;
        @(posedge clk); #1;
        get(sel, bz, dn, ps, er, fv, fm, ab);
        check($sformatf("done_drop[%0d]", sel), 32'(dn), 0);
        for (int i = 0; i < 80; i++) begin
            if (!busy1 && !busy2 && !busy3) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    vec_t tbl[7];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         e;
        logic [1:0] efv;
        logic [6:0] efm;
        logic       eps;
        bit         saw;
        int         dq[$];
        int         d0, d1, d2;

        tbl[0] = '{7'h00, 7'h00, 7'h00, 0, 2'b00, 7'h00, 1'b1};  // healthy unit
        tbl[1] = '{7'h00, 7'h40, 7'h00, 1, 2'b11, 7'h40, 1'b0};  // AND stuck-at-0
        tbl[2] = '{7'h20, 7'h00, 7'h00, 4, 2'b00, 7'h20, 1'b0};  // NOT drives a
        tbl[3] = '{7'h00, 7'h00, 7'h01, 3, 2'b01, 7'h01, 1'b0};  // NOR stuck-at-1
        tbl[4] = '{7'h08, 7'h00, 7'h00, 4, 2'b00, 7'h08, 1'b0};  // XOR inverted
        tbl[5] = '{7'h00, 7'h10, 7'h00, 3, 2'b01, 7'h10, 1'b0};  // OR stuck-at-0
        tbl[6] = '{7'h00, 7'h00, 7'h02, 1, 2'b11, 7'h02, 1'b0};  // NAND stuck-at-1

        rst_n = 1'b0;
        start = 1'b0;
        inv_m = '0;
        sa0_m = '0;
        sa1_m = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy1), 0);
        check("reset_done", 32'(done1), 0);
        check("reset_pass", 32'(pass1), 0);
        check("reset_err", 32'(err1), 0);
        check("reset_ab", 32'({a1, b1}), 0);
        check("reset_fail", 32'({fv1, fm1}), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            inv_m = tbl[i].inv;
            sa0_m = tbl[i].sa0;
            sa1_m = tbl[i].sa1;
            run(1, 1, -1);
            check_results(1, tbl[i].err, tbl[i].fv, tbl[i].fm, tbl[i].ps);
            settle_all(1);
        end

        // Three passes with NOR stuck-at-1; the 2-bit counter saturates at 3.
        inv_m = '0;
        sa0_m = '0;
        sa1_m = 7'h01;
        run(2, 3, -1);
        check_results(2, 9, 2'b01, 7'h01, 1'b0);
        check_results(3, 3, 2'b01, 7'h01, 1'b0);
        settle_all(2);

        // Reset during the second vector of a failing run.
        sa1_m = '0;
        inv_m = 7'h20;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_ab", 32'({a1, b1}), 32'(2'b01));
        check("pre_reset_err", 32'(err1), 1);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", 32'({busy1, busy2, busy3}), 0);
        check("midrun_reset_err", 32'(err1), 0);
        check("midrun_reset_ab", 32'({a1, b1}), 0);
        check("midrun_reset_fail", 32'({fv1, fm1}), 0);
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done1 || busy1) saw = 1'b1;
        end
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (done1 || busy1 || done2) saw = 1'b1;
        end
        check("no_done_after_reset", 32'(saw), 0);
        inv_m = '0;
        run(1, 1, -1);
        check_results(1, 0, 2'b00, 7'h00, 1'b1);
        settle_all(1);

        // A start pulse mid-run must neither disturb nor queue a run.
        run(1, 1, 5);
        check_results(1, 0, 2'b00, 7'h00, 1'b1);
        settle_all(1);
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done1 || busy1) saw = 1'b1;
        end
        check("no_queued_run", 32'(saw), 0);

        // start held high: runs chain, the next one starting as done is seen in IDLE.
        start = 1'b1;
        for (int c = 0; c < 42; c++) begin
            @(posedge clk); #1;
            if (done1) dq.push_back(c);
        end
        start = 1'b0;
        check("held_done_count", 32'(dq.size()), 3);
        d0 = (dq.size() > 0) ? dq[0] : -1;
        d1 = (dq.size() > 1) ? dq[1] : -1;
        d2 = (dq.size() > 2) ? dq[2] : -1;
        check("held_first_done", 32'(d0), 13);
        check("held_spacing_1", 32'(d1 - d0), 14);
        check("held_spacing_2", 32'(d2 - d1), 14);
        settle_all(1);

        // Random sparse fault patterns against the reference sweep.
        for (int it = 0; it < 10; it++) begin
            inv_m = 7'($urandom) & 7'($urandom) & 7'($urandom);
            sa0_m = 7'($urandom) & 7'($urandom) & 7'($urandom);
            sa1_m = 7'($urandom) & 7'($urandom) & 7'($urandom);
            if (it % 2 == 0) begin
                model_run(1, 8, e, efv, efm, eps);
                run(1, 1, -1);
                check_results(1, e, efv, efm, eps);
                settle_all(1);
            end else begin
                run(2, 3, -1);
                model_run(3, 8, e, efv, efm, eps);
                check_results(2, e, efv, efm, eps);
                model_run(3, 2, e, efv, efm, eps);
                check_results(3, e, efv, efm, eps);
                settle_all(2);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
